// File: rtl/viterbi_pkg.sv
// Shared constants, types and trellis helpers for the K=7, rate-1/2 Viterbi
// decoder datapath.
//   NS      : number of trellis states (2^(K-1))
//   BM_W    : branch-metric width
//   PM_W    : stored path-metric width
//   INIT_PM : starting metric of every state except state 0
//   pred0/pred1 : the two predecessor states of a destination state
//   init_pm     : frame-start metric of a given state
package viterbi_pkg;

  localparam int K       = 7;
  localparam int ST_W    = K - 1;
  localparam int NS      = 1 << ST_W;
  localparam int BM_W    = 2;
  localparam int PM_W    = 8;
  localparam int INIT_PM = 64;

  typedef logic [PM_W-1:0] pm_t;
  typedef logic [PM_W:0]   pm_ext_t;
  typedef logic [BM_W-1:0] bm_t;
  typedef logic [ST_W-1:0] state_t;

  // Predecessor on path_0: low K-2 state bits shifted up, a 0 shifted in.
  function automatic state_t pred0(input int unsigned n);
    state_t s;
    s = state_t'(n);
    return {s[ST_W-2:0], 1'b0};
  endfunction

  // Predecessor on path_1: same shift with a 1 shifted in.
  function automatic state_t pred1(input int unsigned n);
    state_t s;
    s = state_t'(n);
    return {s[ST_W-2:0], 1'b1};
  endfunction

  // State 0 starts at 0 so every other state is INIT_PM behind it.
  function automatic pm_t init_pm(input int unsigned n);
    return (n == 0) ? '0 : pm_t'(INIT_PM);
  endfunction

endpackage

// File: rtl/acs_pm_array_if.sv
// Symbol-level bus between the branch-metric units, the ACS array and the
// traceback memory.
//   start      : frame start / metric re-initialisation
//   in_valid   : bm0_bus/bm1_bus carry a symbol this cycle
//   bm0_bus    : path_0 branch metric for state n at [n*BM_W +: BM_W]
//   bm1_bus    : path_1 branch metric, same packing
//   dec_out    : survivor decision per state (1 = path_1 chosen)
//   dec_valid  : dec_out valid for one cycle
//   best_state : lowest-index state holding the minimum metric
//   best_valid : best_state valid for one cycle
//   norm_flag  : metrics were normalised on this update
// master = metric source side, slave = the ACS array.
interface acs_pm_array_if;
  import viterbi_pkg::*;

  logic               start;
  logic               in_valid;
  logic [NS*BM_W-1:0] bm0_bus;
  logic [NS*BM_W-1:0] bm1_bus;
  logic [NS-1:0]      dec_out;
  logic               dec_valid;
  state_t             best_state;
  logic               best_valid;
  logic               norm_flag;

  modport master (
    output start, in_valid, bm0_bus, bm1_bus,
    input  dec_out, dec_valid, best_state, best_valid, norm_flag
  );

  modport slave (
    input  start, in_valid, bm0_bus, bm1_bus,
    output dec_out, dec_valid, best_state, best_valid, norm_flag
  );

endinterface

// File: rtl/acs_node.sv
// One add-compare-select node of the trellis.
//   src0/src1 : path metrics of the path_0 / path_1 predecessors
//   bm0/bm1   : branch metrics for the two incoming transitions
//   sel       : surviving candidate metric, one bit wider than a stored metric
//   dec       : 1 when the path_1 candidate survived
module acs_node
  import viterbi_pkg::*;
(
  input  pm_t     src0,
  input  pm_t     src1,
  input  bm_t     bm0,
  input  bm_t     bm1,
  output pm_ext_t sel,
  output logic    dec
);

  pm_ext_t c0;
  pm_ext_t c1;

  // Sums are formed one bit wider so a metric near the top of its range
  // cannot wrap before the compare.
  always_comb begin
    c0 = pm_ext_t'(src0) + pm_ext_t'(bm0);
    c1 = pm_ext_t'(src1) + pm_ext_t'(bm1);
  end

  // Strict compare: a tie keeps path_0.
  always_comb begin
    if (c1 < c0) begin
      sel = c1;
      dec = 1'b1;
    end else begin
      sel = c0;
      dec = 1'b0;
    end
  end

endmodule

// File: rtl/acs_pm_array.sv
// 64-state add-compare-select array with path-metric storage.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : slave side of acs_pm_array_if (branch metrics in; decisions,
//         best state and normalisation flag out)
// Each valid symbol updates all path metrics in one cycle and registers the
// survivor decisions; the best state follows one cycle later from the
// updated metrics.
module acs_pm_array
  import viterbi_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  acs_pm_array_if.slave bus
);

  localparam pm_ext_t NORM_SUB = pm_ext_t'(1) << (PM_W - 1);
  localparam pm_ext_t PM_MAX   = {1'b0, {PM_W{1'b1}}};

  pm_t           pm_q   [NS];
  pm_t           src    [NS];
  pm_ext_t       sel    [NS];
  pm_t           next_pm[NS];
  logic [NS-1:0] dec;
  logic          all_msb;

  logic [NS-1:0] dec_out_q;
  logic          dec_valid_q;
  logic          norm_flag_q;
  state_t        best_state_q;
  logic          best_valid_q;

  pm_t           min_val;
  state_t        min_idx;

  // The first symbol of a frame reads the initial vector directly, so a
  // frame can start back-to-back with the previous one.
  always_comb begin
    for (int n = 0; n < NS; n++) begin
      src[n] = (bus.start && bus.in_valid) ? init_pm(n) : pm_q[n];
    end
  end

  for (genvar n = 0; n < NS; n++) begin : g_acs
    acs_node u_node (
      .src0 (src[pred0(n)]),
      .src1 (src[pred1(n)]),
      .bm0  (bus.bm0_bus[n*BM_W +: BM_W]),
      .bm1  (bus.bm1_bus[n*BM_W +: BM_W]),
      .sel  (sel[n]),
      .dec  (dec[n])
    );
  end

  // Once every survivor has its top stored bit set, subtracting that bit
  // from all of them keeps their differences and frees headroom. The
  // saturation clamp is only a safety net for an out-of-range bit that a
  // bounded metric spread cannot produce.
  always_comb begin
    pm_ext_t tmp;
    all_msb = 1'b1;
    tmp     = '0;
    for (int n = 0; n < NS; n++) begin
      all_msb = all_msb & sel[n][PM_W-1];
    end
    for (int n = 0; n < NS; n++) begin
      tmp        = all_msb ? (sel[n] - NORM_SUB) : sel[n];
      next_pm[n] = (tmp > PM_MAX) ? PM_MAX[PM_W-1:0] : tmp[PM_W-1:0];
    end
  end

  // Minimum search over the stored metrics. The strict compare walking up
  // from state 0 makes ties resolve to the lowest index.
  always_comb begin
    min_val = pm_q[0];
    min_idx = '0;
    for (int n = 1; n < NS; n++) begin
      if (pm_q[n] < min_val) begin
        min_val = pm_q[n];
        min_idx = state_t'(n);
      end
    end
  end

  // Metric registers and decision outputs. An idle cycle with start set
  // re-initialises the metrics; dec_out keeps its last value when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NS; n++) begin
        pm_q[n] <= init_pm(n);
      end
      dec_out_q   <= '0;
      dec_valid_q <= 1'b0;
      norm_flag_q <= 1'b0;
    end else if (bus.in_valid) begin
      for (int n = 0; n < NS; n++) begin
        pm_q[n] <= next_pm[n];
      end
      dec_out_q   <= dec;
      dec_valid_q <= 1'b1;
      norm_flag_q <= all_msb;
    end else begin
      if (bus.start) begin
        for (int n = 0; n < NS; n++) begin
          pm_q[n] <= init_pm(n);
        end
      end
      dec_valid_q <= 1'b0;
      norm_flag_q <= 1'b0;
    end
  end

  // The best state is captured while dec_valid is high, i.e. from the
  // metrics that symbol just wrote, so it trails dec_valid by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_state_q <= '0;
      best_valid_q <= 1'b0;
    end else begin
      best_valid_q <= dec_valid_q;
      if (dec_valid_q) begin
        best_state_q <= min_idx;
      end
    end
  end

  assign bus.dec_out    = dec_out_q;
  assign bus.dec_valid  = dec_valid_q;
  assign bus.norm_flag  = norm_flag_q;
  assign bus.best_state = best_state_q;
  assign bus.best_valid = best_valid_q;

endmodule
